// File: rtl/seq_det_scheduler.sv
// Shared Mealy overlapping-pattern detector, time-multiplexed over NUM_CH serial streams by a round-robin arbiter.
// Optional per-channel saturating hit counters are enabled with `define SEQ_DET_HIT_CNT_EN.
module seq_det_scheduler #(
    parameter int                 NUM_CH  = 4,
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b0101
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] in_valid,
    input  logic [NUM_CH-1:0] in_bit,
    output logic [NUM_CH-1:0] in_ready,
    input  logic [NUM_CH-1:0] ch_clr,
    output logic [NUM_CH-1:0] hit,
    output logic              busy
`ifdef SEQ_DET_HIT_CNT_EN
    ,
    output logic [NUM_CH*8-1:0] hit_cnt
`endif
);

    localparam int SW = $clog2(PAT_LEN);
    localparam int PW = $clog2(NUM_CH);

    // Longest suffix of (first s pattern bits, b) that is a proper prefix of PATTERN.
    function automatic int kmp_next(input int s, input int b);
        int   best;
        int   c;
        logic ok;
        best = 0;
        for (int k = 1; k < PAT_LEN; k++) begin
            if (k <= s + 1) begin
                ok = 1'b1;
                for (int m = 0; m < k; m++) begin
                    c = s + 1 - k + m;
                    if (c == s) begin
                        if (PATTERN[PAT_LEN-1-m] != b[0]) ok = 1'b0;
                    end else if (PATTERN[PAT_LEN-1-c] != PATTERN[PAT_LEN-1-m]) begin
                        ok = 1'b0;
                    end
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

    function automatic logic [2*PAT_LEN*SW-1:0] build_tbl();
        logic [2*PAT_LEN*SW-1:0] t;
        t = '0;
        for (int s = 0; s < PAT_LEN; s++) begin
            for (int b = 0; b < 2; b++) begin
                t[(2*s+b)*SW +: SW] = SW'(kmp_next(s, b));
            end
        end
        return t;
    endfunction

    localparam logic [2*PAT_LEN*SW-1:0] NXT_TBL = build_tbl();

    logic [SW-1:0]     st [NUM_CH];
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     win;
    logic              found;
    int                idx;
    logic [SW-1:0]     cur;
    logic              cur_bit;
    logic [SW-1:0]     nxt;
    logic [NUM_CH-1:0] hit_nxt;

    // Round-robin search starting one past the last winner.
    always_comb begin
        in_ready = '0;
        found    = 1'b0;
        win      = '0;
        idx      = 0;
        for (int off = 1; off <= NUM_CH; off++) begin
            idx = (int'(ptr) + off) % NUM_CH;
            if (!found && in_valid[idx]) begin
                found         = 1'b1;
                in_ready[idx] = 1'b1;
                win           = PW'(idx);
            end
        end
    end

    always_comb begin
        cur     = st[win];
        cur_bit = in_bit[win];
        nxt     = NXT_TBL[(2*int'(cur) + int'(cur_bit))*SW +: SW];
        hit_nxt = '0;
        if (found && (cur == SW'(PAT_LEN-1)) && (cur_bit == PATTERN[0]) && !ch_clr[win])
            hit_nxt[win] = 1'b1;
    end

    // Clear is applied after the write-back so it overrides a same-cycle transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) st[i] <= '0;
            ptr  <= PW'(NUM_CH-1);
            hit  <= '0;
            busy <= 1'b0;
        end else begin
            busy <= found;
            hit  <= hit_nxt;
            if (found) begin
                ptr     <= win;
                st[win] <= nxt;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_clr[i]) st[i] <= '0;
            end
        end
    end

`ifdef SEQ_DET_HIT_CNT_EN
    logic [7:0] cnt [NUM_CH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_clr[i])
                    cnt[i] <= '0;
                else if (hit_nxt[i] && (cnt[i] != 8'hFF))
                    cnt[i] <= cnt[i] + 8'd1;
            end
        end
    end

    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) hit_cnt[8*i +: 8] = cnt[i];
    end
`endif

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Directed, table-driven bench for seq_det_scheduler (4 channels, pattern 0101).
module tb_seq_det_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_valid, in_bit, ch_clr;
    logic [3:0] in_ready, hit;
    logic       busy;
    logic [3:0] ready_s;
`ifdef SEQ_DET_HIT_CNT_EN
    logic [31:0] hit_cnt;
`endif

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic [3:0] bits;
        logic [3:0] clr;
        logic [3:0] ready;
        logic [3:0] hit;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    seq_det_scheduler #(
        .NUM_CH (4),
        .PAT_LEN(4),
        .PATTERN(4'b0101)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_bit  (in_bit),
        .in_ready(in_ready),
        .ch_clr  (ch_clr),
        .hit     (hit),
        .busy    (busy)
`ifdef SEQ_DET_HIT_CNT_EN
        ,
        .hit_cnt (hit_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Drive inputs just after a posedge, capture in_ready at the negedge, return 1ns after the next posedge.
    task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [3:0] b, input logic [3:0] c);
        rst      = r;
        in_valid = v;
        in_bit   = b;
        ch_clr   = c;
        @(negedge clk);
        ready_s = in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic addVec(input logic r, input logic [3:0] v, input logic [3:0] b, input logic [3:0] c,
                          input logic [3:0] rdy, input logic [3:0] h, input logic bz);
        vec_t t;
        t.rst = r; t.valid = v; t.bits = b; t.clr = c; t.ready = rdy; t.hit = h; t.busy = bz;
        vecs.push_back(t);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000);
    endtask

    task automatic sendBit(input string name, input int ch, input logic b, input logic c, input logic exp_hit);
        logic [3:0] onehot;
        onehot = 4'b0001 << ch;
        applyStimulus(1'b0, onehot, b ? onehot : 4'b0000, c ? onehot : 4'b0000);
        checkOutput({name, "_ready"}, {28'd0, ready_s}, {28'd0, onehot});
        checkOutput({name, "_hit"}, {28'd0, hit}, {28'd0, exp_hit ? onehot : 4'b0000});
    endtask

    initial begin
        logic [3:0] p0, p1;
        int         k0, k1, hits0, hits1, hits;
        logic [3:0] v, b;

        rst = 1'b1; in_valid = '0; in_bit = '0; ch_clr = '0;
        @(posedge clk); #1;

        // Reset checks.
        doReset();
        checkOutput("rst_hit", {28'd0, hit}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_ready_idle", {28'd0, ready_s}, 32'd0);

        // Round-robin over all four, then over 1 and 3, then idle.
        addVec(0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1);
        addVec(0, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1);
        addVec(0, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1);
        addVec(0, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 1);
        addVec(0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1);
        addVec(0, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1);
        addVec(0, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1);
        addVec(0, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 1);
        addVec(0, 4'b1010, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1);
        addVec(0, 4'b1010, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 1);
        addVec(0, 4'b1010, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1);
        addVec(0, 4'b1010, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 1);
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        // ch2 overlap: 010101 hits after bits 4 and 6.
        addVec(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        addVec(0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1);
        addVec(0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1);
        addVec(0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1);
        addVec(0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 1);
        addVec(0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1);
        addVec(0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 1);
        // ch2: 110101 hits only after bit 6.
        addVec(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        addVec(0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1);
        addVec(0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1);
        addVec(0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1);
        addVec(0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1);
        addVec(0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1);
        addVec(0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].bits, vecs[i].clr);
            checkOutput($sformatf("vec%0d_ready", i), {28'd0, ready_s}, {28'd0, vecs[i].ready});
            checkOutput($sformatf("vec%0d_hit", i), {28'd0, hit}, {28'd0, vecs[i].hit});
            checkOutput($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
        end

        // Interleave: ch0 sends 0101, ch1 sends 0100, grants alternate starting with ch0.
        doReset();
        p0 = 4'b0101; p1 = 4'b0100;
        k0 = 0; k1 = 0; hits0 = 0; hits1 = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            v = {2'b00, k1 < 4, k0 < 4};
            b = {2'b00, (k1 < 4) ? p1[3-k1] : 1'b0, (k0 < 4) ? p0[3-k0] : 1'b0};
            applyStimulus(1'b0, v, b, 4'b0000);
            checkOutput($sformatf("ilv%0d_ready", cyc), {28'd0, ready_s}, (cyc % 2 == 0) ? 32'd1 : 32'd2);
            checkOutput($sformatf("ilv%0d_hit", cyc), {28'd0, hit}, (cyc == 6) ? 32'd1 : 32'd0);
            if (cyc % 2 == 0) k0++; else k1++;
            hits0 += int'(hit[0]);
            hits1 += int'(hit[1]);
        end
        checkOutput("ilv_hits_ch0", hits0, 32'd1);
        checkOutput("ilv_hits_ch1", hits1, 32'd0);

        // Clear collision on ch3: clear wins over the completing bit.
        doReset();
        sendBit("clr_a", 3, 1'b0, 1'b0, 1'b0);
        sendBit("clr_b", 3, 1'b1, 1'b0, 1'b0);
        sendBit("clr_c", 3, 1'b0, 1'b0, 1'b0);
        sendBit("clr_d", 3, 1'b1, 1'b1, 1'b0);
        sendBit("clr_e", 3, 1'b0, 1'b0, 1'b0);
        sendBit("clr_f", 3, 1'b1, 1'b0, 1'b0);
        sendBit("clr_g", 3, 1'b0, 1'b0, 1'b0);
        sendBit("clr_h", 3, 1'b1, 1'b0, 1'b1);

        // Mid-stream reset on ch1 discards the partial match.
        doReset();
        sendBit("mrst_a", 1, 1'b0, 1'b0, 1'b0);
        sendBit("mrst_b", 1, 1'b1, 1'b0, 1'b0);
        sendBit("mrst_c", 1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000);
        sendBit("mrst_d", 1, 1'b1, 1'b0, 1'b0);
        sendBit("mrst_e", 1, 1'b0, 1'b0, 1'b0);
        sendBit("mrst_f", 1, 1'b1, 1'b0, 1'b0);
        sendBit("mrst_g", 1, 1'b0, 1'b0, 1'b0);
        sendBit("mrst_h", 1, 1'b1, 1'b0, 1'b1);

`ifdef SEQ_DET_HIT_CNT_EN
        // 300 hits on ch0: 0101 then 299 repeats of 01.
        doReset();
        hits = 0;
        for (int i = 0; i < 602; i++) begin
            applyStimulus(1'b0, 4'b0001, {3'b000, i[0]}, 4'b0000);
            hits += int'(hit[0]);
            if (i == 3) checkOutput("cnt_first", {24'd0, hit_cnt[7:0]}, 32'd1);
        end
        checkOutput("cnt_hits_seen", hits, 32'd300);
        checkOutput("cnt_sat", {24'd0, hit_cnt[7:0]}, 32'd255);
        checkOutput("cnt_others", {8'd0, hit_cnt[31:8]}, 32'd0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0001);
        checkOutput("cnt_clr", {24'd0, hit_cnt[7:0]}, 32'd0);
`else
        hits = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
